// File: rtl/pacman_pkg.sv
// Shared definitions for the pellet tracker slice.
// Purpose: grid geometry, the default pellet and power-pellet layouts, the
//          pellet count derived from the layout, colour constants, the tracker
//          state enum and small axis-mapping helpers used by the eat pipeline
//          and the renderer.
// Ports:   none (package).
package pacman_pkg;

    localparam int COLS       = 16;
    localparam int ROWS       = 12;
    localparam int CELL_SHIFT = 5;
    localparam int IDX_W      = $clog2((COLS > ROWS) ? COLS : ROWS);

    typedef logic [COLS-1:0]            row_t;
    typedef logic [ROWS-1:0][COLS-1:0]  mask_t;

    // Row 0 is the rightmost element; bit c of a row is column c.
    // Rows 0 and 11 full, rows 1..4 carry the two edge columns: 40 pellets.
    localparam mask_t PELLET_MASK = {16'hFFFF, {6{16'h0000}}, {4{16'h8001}}, 16'hFFFF};
    // The four corner cells.
    localparam mask_t POWER_MASK  = {16'h8001, {10{16'h0000}}, 16'h8001};

    function automatic int count_bits(input mask_t m);
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m[r][c]) n++;
        return n;
    endfunction

    localparam int PELLET_TOTAL = count_bits(PELLET_MASK);

    localparam logic [11:0] PELLET_RGB = 12'hFFF;
    localparam logic [11:0] BLANK_RGB  = 12'h000;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_DONE} tracker_state_t;

    // One axis of a pixel position mapped onto the grid.
    typedef struct packed {
        logic                  ok;   // inside the grid on this axis
        logic [IDX_W-1:0]      idx;  // cell index
        logic [CELL_SHIFT-1:0] off;  // pixel offset inside the cell
    } axis_t;

    function automatic axis_t map_axis(input logic [9:0] p, input int origin, input int cells);
        axis_t a;
        int    d;
        d     = int'(p) - origin;
        a.ok  = (d >= 0) && ((d >> CELL_SHIFT) < cells);
        a.idx = IDX_W'(d >> CELL_SHIFT);
        a.off = CELL_SHIFT'(d);
        return a;
    endfunction

    // |off - cell centre| <= radius
    function automatic logic near_centre(input logic [CELL_SHIFT-1:0] off, input int radius);
        int d;
        d = int'(off) - (1 << (CELL_SHIFT - 1));
        if (d < 0) d = -d;
        return (d <= radius);
    endfunction

endpackage

// File: rtl/pellet_tracker_if.sv
// Bundle of the pellet tracker's control, position, raster and result signals.
// Ports: master drives start/ack/move_tick/lose/pacX/pacY/hCount/vCount/bright
//        and observes the results; slave (the tracker) is the mirror image.
interface pellet_tracker_if;
    logic        start;
    logic        ack;
    logic        move_tick;
    logic        lose;
    logic [9:0]  pacX;
    logic [9:0]  pacY;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic [15:0] score;
    logic [7:0]  pellets_left;
    logic        win;
    logic        eat_pulse;
    logic        power_pulse;
    logic        pelletFill;
    logic [11:0] rgb;

    modport master (
        output start, ack, move_tick, lose, pacX, pacY, hCount, vCount, bright,
        input  score, pellets_left, win, eat_pulse, power_pulse, pelletFill, rgb
    );

    modport slave (
        input  start, ack, move_tick, lose, pacX, pacY, hCount, vCount, bright,
        output score, pellets_left, win, eat_pulse, power_pulse, pelletFill, rgb
    );
endinterface

// File: rtl/pellet_bitmap.sv
// ROWS x COLS pellet storage.
// Ports: clk, reset_n (async, active-low, clears every bit);
//        load_en/load_row/load_bits  - write a whole row;
//        clr_en/clr_row/clr_col      - clear a single bit;
//        eat_row/eat_col -> eat_bit  - scoring read (combinational);
//        pix_row/pix_col -> pix_bit  - render read (combinational).
module pellet_bitmap #(
    parameter int COLS  = pacman_pkg::COLS,
    parameter int ROWS  = pacman_pkg::ROWS,
    parameter int IDX_W = pacman_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_row,
    input  logic [COLS-1:0]  load_bits,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_row,
    input  logic [IDX_W-1:0] clr_col,
    input  logic [IDX_W-1:0] eat_row,
    input  logic [IDX_W-1:0] eat_col,
    output logic             eat_bit,
    input  logic [IDX_W-1:0] pix_row,
    input  logic [IDX_W-1:0] pix_col,
    output logic             pix_bit
);
    import pacman_pkg::*;

    logic [COLS-1:0] cells [ROWS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) cells[r] <= '0;
        end else if (load_en) begin
            cells[load_row] <= load_bits;
        end else if (clr_en) begin
            cells[clr_row][clr_col] <= 1'b0;
        end
    end

    assign eat_bit = cells[eat_row][eat_col];
    assign pix_bit = cells[pix_row][pix_col];

endmodule

// File: rtl/pellet_tracker.sv
// Pellet tracker: maps Pac-Man's position onto the pellet grid, clears eaten
// pellets, keeps the saturating score and the remaining count, flags a win,
// and renders the pellet layer of the VGA image.
// Ports: clk, reset_n (async, active-low), bus (pellet_tracker_if.slave).
// Config macro: PELLET_POWER_EN - corner power pellets score POWER_POINTS,
//               pulse power_pulse and render as 7x7 dots; when undefined all
//               pellets are normal and power_pulse is tied low.
module pellet_tracker #(
    parameter int COLS          = pacman_pkg::COLS,
    parameter int ROWS          = pacman_pkg::ROWS,
    parameter int CELL_SHIFT    = pacman_pkg::CELL_SHIFT,
    parameter int X_ORIGIN      = 0,
    parameter int Y_ORIGIN      = 0,
    parameter int HIT_WIN       = 4,
    parameter int PELLET_POINTS = 10,
    parameter int POWER_POINTS  = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    pellet_tracker_if.slave  bus
);
    import pacman_pkg::*;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
    localparam logic [15:0]      PTS_N    = 16'(PELLET_POINTS);
    localparam logic [15:0]      PTS_P    = 16'(POWER_POINTS);

    tracker_state_t   state;
    logic [IDX_W-1:0] load_cnt;
    logic [15:0]      score;
    logic [7:0]       pellets_left;
    logic             win, eat_pulse, fill_q;
    logic [11:0]      rgb_q;

    axis_t            ex, ey, rx, ry;
    logic             hit_c, vld_p1, eat_bit, eat_now, pix_bit, fill_c;
    logic             pwr_eat, pwr_pix;
    logic [IDX_W-1:0] col_p1, row_p1;
    logic [15:0]      pts;
    int               dot_r;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        ex      = map_axis(bus.pacX, X_ORIGIN, COLS);
        ey      = map_axis(bus.pacY, Y_ORIGIN, ROWS);
        rx      = map_axis(bus.hCount, X_ORIGIN, COLS);
        ry      = map_axis(bus.vCount, Y_ORIGIN, ROWS);
        hit_c   = ex.ok && ey.ok && near_centre(ex.off, HIT_WIN) && near_centre(ey.off, HIT_WIN);
        // Bitmap is read here, after any clear from the previous tick has landed.
        eat_now = vld_p1 && (state == ST_PLAY) && eat_bit;
`ifdef PELLET_POWER_EN
        pwr_eat = POWER_MASK[row_p1][col_p1];
        pwr_pix = POWER_MASK[ry.idx][rx.idx];
`else
        pwr_eat = 1'b0;
        pwr_pix = 1'b0;
`endif
        pts     = pwr_eat ? PTS_P : PTS_N;
        dot_r   = pwr_pix ? 3 : 1;
        fill_c  = rx.ok && ry.ok && pix_bit && near_centre(rx.off, dot_r) && near_centre(ry.off, dot_r);
    end

    // ---- stage 1: cell coordinates of the tick ----
    always_ff @(posedge clk) begin
        if (bus.move_tick) begin
            col_p1 <= ex.idx;
            row_p1 <= ey.idx;
        end
    end

    // ---- stage 2: score / count update, plus the round FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            load_cnt     <= '0;
            vld_p1       <= 1'b0;
            score        <= '0;
            pellets_left <= '0;
            win          <= 1'b0;
            eat_pulse    <= 1'b0;
        end else begin
            vld_p1    <= bus.move_tick && (state == ST_PLAY) && hit_c;
            eat_pulse <= eat_now;
            if (eat_now) begin
                score        <= sat_add16(score, pts);
                pellets_left <= pellets_left - 8'd1;
            end
            case (state)
                ST_IDLE: if (bus.start) begin
                    state    <= ST_LOAD;
                    load_cnt <= '0;
                end
                ST_LOAD: begin
                    score <= '0;
                    if (load_cnt == LAST_ROW) begin
                        state        <= ST_PLAY;
                        pellets_left <= 8'(PELLET_TOTAL);
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                ST_PLAY: if (bus.lose) begin
                    state <= ST_DONE;
                    win   <= 1'b0;
                end else if (pellets_left == 8'd0) begin
                    state <= ST_DONE;
                    win   <= 1'b1;
                end
                ST_DONE: if (bus.ack) begin
                    state <= ST_IDLE;
                    win   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PELLET_POWER_EN
    logic power_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) power_q <= 1'b0;
        else          power_q <= eat_now && pwr_eat;
    end
    assign bus.power_pulse = power_q;
`else
    assign bus.power_pulse = 1'b0;
`endif

    // ---- render: one registered stage behind the raster ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= 1'b0;
            rgb_q  <= BLANK_RGB;
        end else begin
            fill_q <= fill_c;
            rgb_q  <= (bus.bright && fill_c) ? PELLET_RGB : BLANK_RGB;
        end
    end

    pellet_bitmap #(.COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W)) u_bitmap (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_en  (state == ST_LOAD),
        .load_row (load_cnt),
        .load_bits(PELLET_MASK[load_cnt]),
        .clr_en   (eat_now),
        .clr_row  (row_p1),
        .clr_col  (col_p1),
        .eat_row  (row_p1),
        .eat_col  (col_p1),
        .eat_bit  (eat_bit),
        .pix_row  (ry.idx),
        .pix_col  (rx.idx),
        .pix_bit  (pix_bit)
    );

    assign bus.score        = score;
    assign bus.pellets_left = pellets_left;
    assign bus.win          = win;
    assign bus.eat_pulse    = eat_pulse;
    assign bus.pelletFill   = fill_q;
    assign bus.rgb          = rgb_q;

endmodule
